// File: rtl/uart_transceiver_if.sv
// Byte-level handshake between the peripheral block (master) and the UART engine (slave).
interface uart_transceiver_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_status;
  logic       tx_end;
  logic [7:0] rx_data;
  logic       rx_end;
  logic       rx_ferr;

  modport master (
    output tx_data, tx_start,
    input  tx_status, tx_end, rx_data, rx_end, rx_ferr
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_status, tx_end, rx_data, rx_end, rx_ferr
  );
endinterface

// File: rtl/uart_transceiver.sv
// 8N1 UART engine: shared x16 oversample tick, independent rx and tx FSMs.
module uart_transceiver #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rx,
  output logic                uart_tx,
  uart_transceiver_if.slave   bus
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;

  tx_state_t r_tx_state, w_tx_state_nxt;
  logic [3:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0] r_tx_idx, w_tx_idx_nxt;
  logic [7:0] r_tx_shift, w_tx_shift_nxt;
  logic       r_tx_line, w_tx_line_nxt;
  logic       r_tx_go, w_tx_go_nxt;
  logic       r_tx_end, w_tx_end_nxt;

  rx_state_t r_rx_state, w_rx_state_nxt;
  logic       r_rx_meta, r_rxs;
  logic [3:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0] r_rx_idx, w_rx_idx_nxt;
  logic [7:0] r_rx_shift, w_rx_shift_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_end, w_rx_end_nxt;
  logic       r_rx_ferr, w_rx_ferr_nxt;

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  // Free-running oversample divider; wraps every DIV clocks and raises w_tick on the wrap.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end

  // TX next-state and datapath: a leading tick wait, then 10 bits of 16 ticks each.
  // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_line_nxt  = r_tx_line;
    w_tx_go_nxt    = r_tx_go;
    w_tx_end_nxt   = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_tx_line_nxt = 1'b1;
        if (bus.tx_start) begin
          w_tx_shift_nxt = bus.tx_data;
          w_tx_go_nxt    = 1'b0;
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (w_tick) begin
          if (!r_tx_go) begin
            // First tick after acceptance: the start bit begins here.
            w_tx_go_nxt   = 1'b1;
            w_tx_line_nxt = 1'b0;
            w_tx_cnt_nxt  = '0;
          end else if (r_tx_cnt == 4'd15) begin
            w_tx_line_nxt  = r_tx_shift[0];
            w_tx_shift_nxt = r_tx_shift >> 1;
            w_tx_cnt_nxt   = '0;
            w_tx_idx_nxt   = '0;
            w_tx_state_nxt = TX_DATA;
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_tx_cnt == 4'd15) begin
            w_tx_cnt_nxt = '0;
            if (r_tx_idx == 3'd7) begin
              w_tx_line_nxt  = 1'b1;
              w_tx_state_nxt = TX_STOP;
            end else begin
              w_tx_idx_nxt   = r_tx_idx + 3'd1;
              w_tx_line_nxt  = r_tx_shift[0];
              w_tx_shift_nxt = r_tx_shift >> 1;
            end
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_tx_cnt == 4'd15) begin
            w_tx_end_nxt   = 1'b1;
            w_tx_state_nxt = TX_IDLE;
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + 4'd1;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX state and registered line; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
      r_tx_go    <= 1'b0;
      r_tx_end   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_line  <= w_tx_line_nxt;
      r_tx_go    <= w_tx_go_nxt;
      r_tx_end   <= w_tx_end_nxt;
    end
  end

  // Two-stage synchronizer for the asynchronous rx line; resets to the idle level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // RX next-state: mid-bit start check, 16-tick bit-centre sampling, stop check.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_end_nxt   = 1'b0;
    w_rx_ferr_nxt  = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (!r_rxs) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_cnt == 4'd7) begin
            w_rx_cnt_nxt   = '0;
            w_rx_idx_nxt   = '0;
            w_rx_state_nxt = r_rxs ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_cnt == 4'd15) begin
            w_rx_cnt_nxt   = '0;
            w_rx_shift_nxt = {r_rxs, r_rx_shift[7:1]};
            if (r_rx_idx == 3'd7) w_rx_state_nxt = RX_STOP;
            else                  w_rx_idx_nxt   = r_rx_idx + 3'd1;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_rx_cnt == 4'd15) begin
            w_rx_cnt_nxt = '0;
            if (r_rxs) begin
              w_rx_data_nxt  = r_rx_shift;
              w_rx_end_nxt   = 1'b1;
              w_rx_state_nxt = RX_IDLE;
            end else begin
              w_rx_ferr_nxt  = 1'b1;
              w_rx_state_nxt = RX_WAIT_HIGH;
            end
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (r_rxs) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX state, received byte and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= 8'h00;
      r_rx_end   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_end   <= w_rx_end_nxt;
      r_rx_ferr  <= w_rx_ferr_nxt;
    end
  end

  assign uart_tx       = r_tx_line;
  assign bus.tx_status = (r_tx_state == TX_IDLE);
  assign bus.tx_end    = r_tx_end;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_end    = r_rx_end;
  assign bus.rx_ferr   = r_rx_ferr;

endmodule
